wb_master_port: RTL and testbench

WB_MASTER_PORT -- requirements
Module: wb_master_port

---
 rtl/wb_pkg.sv | 13 +
 rtl/wb_master_port_if.sv | 25 ++
 rtl/wb_timeout_cnt.sv | 24 ++
 rtl/wb_master_port.sv | 151 +++++++++++++++
 tb/tb_wb_master_port.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared types and widths for the Wishbone master port
package wb_pkg;

  localparam int WB_DATA_W = 32;
  localparam int WB_SEL_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } wb_state_e;

endpackage

// File: rtl/wb_master_port_if.sv
// rtl/wb_master_port_if.sv - Wishbone classic bus signals with master/slave views
interface wb_master_port_if #(
  parameter int ADDR_W = 32
);
  import wb_pkg::*;

  logic [ADDR_W-1:0]    wb_adr_o;
  logic [WB_DATA_W-1:0] wb_dat_o;
  logic [WB_SEL_W-1:0]  wb_sel_o;
  logic                 wb_we_o;
  logic                 wb_cyc_o;
  logic                 wb_stb_o;
  logic                 wb_ack_i;
  logic [WB_DATA_W-1:0] wb_dat_i;

  modport master (
    output wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o,
    input  wb_ack_i, wb_dat_i
  );

  modport slave (
    input  wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o,
    output wb_ack_i, wb_dat_i
  );
endinterface

// File: rtl/wb_timeout_cnt.sv
// rtl/wb_timeout_cnt.sv - 8-bit bus-cycle counter flagging expiry at LIMIT-1
module wb_timeout_cnt #(
  parameter int LIMIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  logic [7:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt_q <= 8'd0;
    end else if (enable) begin
      cnt_q <= cnt_q + 8'd1;
    end
  end

  assign expire = enable && (cnt_q == 8'(LIMIT - 1));

endmodule

// File: rtl/wb_master_port.sv
// rtl/wb_master_port.sv - cmd/rsp to Wishbone classic master; WB_MASTER_TIMEOUT_EN adds ACK timeout abort
module wb_master_port
  import wb_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int ADDR_W  = 32
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_we,
  input  logic [ADDR_W-1:0]    cmd_adr,
  input  logic [WB_DATA_W-1:0] cmd_dat,
  input  logic [WB_SEL_W-1:0]  cmd_sel,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [WB_DATA_W-1:0] rsp_dat,
  output logic                 rsp_err,
  wb_master_port_if.master     wb
);

  wb_state_e            state_q, state_d;
  logic [ADDR_W-1:0]    adr_q, adr_d;
  logic [WB_DATA_W-1:0] dat_q, dat_d;
  logic [WB_SEL_W-1:0]  sel_q, sel_d;
  logic                 we_q, we_d;
  logic                 cyc_q, cyc_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [WB_DATA_W-1:0] rsp_dat_q, rsp_dat_d;

`ifdef WB_MASTER_TIMEOUT_EN
  logic rsp_err_q, rsp_err_d;
  logic tmo_clear, tmo_en, tmo_expire;

  wb_timeout_cnt #(.LIMIT(TIMEOUT)) u_tmo (
    .clk    (wb_clk_i),
    .rst    (wb_rst_i),
    .clear  (tmo_clear),
    .enable (tmo_en),
    .expire (tmo_expire)
  );

  assign rsp_err = rsp_err_q;
`else
  assign rsp_err = 1'b0;
`endif

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q     <= IDLE;
      adr_q       <= '0;
      dat_q       <= '0;
      sel_q       <= '0;
      we_q        <= 1'b0;
      cyc_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_dat_q   <= '0;
`ifdef WB_MASTER_TIMEOUT_EN
      rsp_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
      sel_q       <= sel_d;
      we_q        <= we_d;
      cyc_q       <= cyc_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_dat_q   <= rsp_dat_d;
`ifdef WB_MASTER_TIMEOUT_EN
      rsp_err_q   <= rsp_err_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    adr_d       = adr_q;
    dat_d       = dat_q;
    sel_d       = sel_q;
    we_d        = we_q;
    cyc_d       = cyc_q;
    rsp_valid_d = rsp_valid_q;
    rsp_dat_d   = rsp_dat_q;
`ifdef WB_MASTER_TIMEOUT_EN
    rsp_err_d   = rsp_err_q;
    tmo_clear   = 1'b0;
    tmo_en      = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          adr_d   = cmd_adr;
          dat_d   = cmd_dat;
          sel_d   = cmd_sel;
          we_d    = cmd_we;
          cyc_d   = 1'b1;
          state_d = BUS;
`ifdef WB_MASTER_TIMEOUT_EN
          tmo_clear = 1'b1;
`endif
        end
      end
      BUS: begin
`ifdef WB_MASTER_TIMEOUT_EN
        tmo_en = 1'b1;
`endif
        // ACK takes priority over a coincident timeout expiry
        if (wb.wb_ack_i) begin
          cyc_d       = 1'b0;
          rsp_dat_d   = we_q ? '0 : wb.wb_dat_i;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
`ifdef WB_MASTER_TIMEOUT_EN
          rsp_err_d   = 1'b0;
        end else if (tmo_expire) begin
          cyc_d       = 1'b0;
          rsp_dat_d   = '0;
          rsp_err_d   = 1'b1;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
`endif
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cyc_d   = 1'b0;
      end
    endcase
  end

  assign cmd_ready   = (state_q == IDLE) && !wb_rst_i;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_dat     = rsp_dat_q;

  // STB always mirrors CYC: classic single transfers only
  assign wb.wb_adr_o = adr_q;
  assign wb.wb_dat_o = dat_q;
  assign wb.wb_sel_o = sel_q;
  assign wb.wb_we_o  = we_q;
  assign wb.wb_cyc_o = cyc_q;
  assign wb.wb_stb_o = cyc_q;

endmodule

// File: tb/tb_wb_master_port.sv
// tb/tb_wb_master_port.sv - directed table-driven bench for wb_master_port with a wb_ram slave model
module tb_wb_master_port;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_we = 1'b0;
  logic [31:0] cmd_adr = '0;
  logic [31:0] cmd_dat = '0;
  logic [3:0]  cmd_sel = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_dat;
  logic        rsp_err;

  int errors = 0;
  int checks = 0;

  wb_master_port_if #(.ADDR_W(32)) wb ();

  wb_master_port #(.TIMEOUT(16), .ADDR_W(32)) dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_we    (cmd_we),
    .cmd_adr   (cmd_adr),
    .cmd_dat   (cmd_dat),
    .cmd_sel   (cmd_sel),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_dat   (rsp_dat),
    .rsp_err   (rsp_err),
    .wb        (wb)
  );

  always #5 clk = ~clk;

  // wb_ram slave: ACK registered ack_wait+1 cycles after CYC&STB is first seen
  logic [31:0] ram [16];
  logic        sl_ack = 1'b0;
  logic [31:0] sl_dat = '0;
  logic        force_ack = 1'b0;
  int          ack_wait = 0;
  int          wait_cnt = 0;

  assign wb.wb_ack_i = sl_ack | force_ack;
  assign wb.wb_dat_i = sl_dat;

  always @(posedge clk) begin
    if (wb.wb_cyc_o && wb.wb_stb_o && !sl_ack) begin
      if (wait_cnt >= ack_wait) begin
        sl_ack   <= 1'b1;
        wait_cnt <= 0;
        if (wb.wb_we_o) begin
          for (int b = 0; b < 4; b++)
            if (wb.wb_sel_o[b]) ram[wb.wb_adr_o[5:2]][8*b +: 8] <= wb.wb_dat_o[8*b +: 8];
        end else begin
          sl_dat <= ram[wb.wb_adr_o[5:2]];
        end
      end else begin
        wait_cnt <= wait_cnt + 1;
      end
    end else begin
      sl_ack   <= 1'b0;
      wait_cnt <= 0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_cmd(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                        input logic [3:0] sel, input int hold,
                        output logic [31:0] rdat, output logic err, output int lat,
                        output int ncyc, output logic [31:0] bus_adr);
    int n;
    logic [31:0] first;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_we = we; cmd_adr = adr; cmd_dat = dat; cmd_sel = sel;
    n = 0;
    while (!cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) chk("accept_timeout", 32'(cmd_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    bus_adr = wb.wb_adr_o;
    lat = 0;
    ncyc = 0;
    while (!rsp_valid && lat < 100) begin
      if (wb.wb_cyc_o) ncyc++;
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    if (!rsp_valid) chk("rsp_timeout", 32'(rsp_valid), 32'd1);
    rdat = rsp_dat;
    err = rsp_err;
    first = rsp_dat;
    // stall the response while offering another command that must not be taken
    for (int h = 0; h < hold; h++) begin
      cmd_valid = 1'b1; cmd_we = 1'b1; cmd_adr = 32'h3C; cmd_sel = 4'hF;
      @(posedge clk);
      @(negedge clk);
      chk("hold_valid", 32'(rsp_valid), 32'd1);
      chk("hold_dat", rsp_dat, first);
      chk("hold_cmd_ready", 32'(cmd_ready), 32'd0);
      chk("hold_cyc", 32'(wb.wb_cyc_o), 32'd0);
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("rsp_drop", 32'(rsp_valid), 32'd0);
  endtask

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic [31:0] exp_dat;
  } vec_t;

  vec_t vecs [8];

  initial begin
    logic [31:0] rdat, badr;
    logic        err;
    int          lat, ncyc, seen;

    for (int i = 0; i < 16; i++) ram[i] = '0;

    vecs[0] = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 32'h0000_0000};
    vecs[1] = '{1'b0, 32'h0000_0010, 32'h0000_0000, 4'hF, 32'hDEAD_BEEF};
    vecs[2] = '{1'b1, 32'h0000_0014, 32'h1122_3344, 4'hF, 32'h0000_0000};
    vecs[3] = '{1'b1, 32'h0000_0014, 32'hAABB_CCDD, 4'h5, 32'h0000_0000};
    vecs[4] = '{1'b0, 32'h0000_0014, 32'h0000_0000, 4'hF, 32'h11BB_33DD};
    vecs[5] = '{1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFF, 4'h8, 32'h0000_0000};
    vecs[6] = '{1'b0, 32'h0000_003C, 32'h0000_0000, 4'hF, 32'hFF00_0000};
    vecs[7] = '{1'b0, 32'h0000_0000, 32'h0000_0000, 4'hF, 32'h0000_0000};

    repeat (3) begin
      @(negedge clk);
      chk("reset_cmd_ready", 32'(cmd_ready), 32'd0);
    end
    rst = 1'b0;
    @(negedge clk);
    chk("reset_cyc", 32'(wb.wb_cyc_o), 32'd0);
    chk("reset_stb", 32'(wb.wb_stb_o), 32'd0);
    chk("reset_we", 32'(wb.wb_we_o), 32'd0);
    chk("reset_adr", wb.wb_adr_o, 32'd0);
    chk("reset_dat", wb.wb_dat_o, 32'd0);
    chk("reset_sel", 32'(wb.wb_sel_o), 32'd0);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_rsp_dat", rsp_dat, 32'd0);
    chk("reset_rsp_err", 32'(rsp_err), 32'd0);
    chk("idle_cmd_ready", 32'(cmd_ready), 32'd1);

    for (int i = 0; i < 8; i++) begin
      do_cmd(vecs[i].we, vecs[i].adr, vecs[i].dat, vecs[i].sel, 0, rdat, err, lat, ncyc, badr);
      chk($sformatf("vec%0d_rsp_dat", i), rdat, vecs[i].exp_dat);
      chk($sformatf("vec%0d_rsp_err", i), 32'(err), 32'd0);
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'd2);
      chk($sformatf("vec%0d_cyc_cycles", i), 32'(ncyc), 32'd2);
      chk($sformatf("vec%0d_bus_adr", i), badr, vecs[i].adr);
    end

    // response stalled for 5 cycles
    do_cmd(1'b0, 32'h14, 32'h0, 4'hF, 5, rdat, err, lat, ncyc, badr);
    chk("stall_rsp_dat", rdat, 32'h11BB_33DD);
    chk("stall_ram_untouched", ram[15], 32'hFF00_0000);

    // spurious ACK while idle
    @(negedge clk);
    force_ack = 1'b1;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      chk("spur_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("spur_cyc", 32'(wb.wb_cyc_o), 32'd0);
      chk("spur_cmd_ready", 32'(cmd_ready), 32'd1);
    end
    force_ack = 1'b0;

    // reset in BUS cycle 3 against a slow slave
    ack_wait = 20;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 32'h10; cmd_sel = 4'hF;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("rstbus_cyc_up", 32'(wb.wb_cyc_o), 32'd1);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rstbus_cyc", 32'(wb.wb_cyc_o), 32'd0);
    chk("rstbus_stb", 32'(wb.wb_stb_o), 32'd0);
    chk("rstbus_adr", wb.wb_adr_o, 32'd0);
    chk("rstbus_cmd_ready", 32'(cmd_ready), 32'd0);
    rst = 1'b0;
    seen = 0;
    repeat (25) begin
      @(posedge clk);
      @(negedge clk);
      if (rsp_valid || wb.wb_cyc_o) seen++;
    end
    chk("rstbus_no_rsp", 32'(seen), 32'd0);
    ack_wait = 0;
    do_cmd(1'b0, 32'h10, 32'h0, 4'hF, 0, rdat, err, lat, ncyc, badr);
    chk("after_rst_dat", rdat, 32'hDEAD_BEEF);
    chk("after_rst_lat", 32'(lat), 32'd2);

`ifdef WB_MASTER_TIMEOUT_EN
    ack_wait = 255;
    do_cmd(1'b0, 32'h10, 32'h0, 4'hF, 0, rdat, err, lat, ncyc, badr);
    chk("tmo_cyc_cycles", 32'(ncyc), 32'd16);
    chk("tmo_rsp_err", 32'(err), 32'd1);
    chk("tmo_rsp_dat", rdat, 32'd0);
    ack_wait = 14;
    do_cmd(1'b0, 32'h10, 32'h0, 4'hF, 0, rdat, err, lat, ncyc, badr);
    chk("edge_ack_err", 32'(err), 32'd0);
    chk("edge_ack_dat", rdat, 32'hDEAD_BEEF);
    chk("edge_ack_cyc", 32'(ncyc), 32'd16);
    ack_wait = 0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
